// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared state encoding, JK drive codes and counter widths for the JK excitation driver
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } drv_state_e;

    // Codes are packed as {j, k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam int SETTLE_W = 4;
    localparam int RETRY_W  = 3;

endpackage

// File: rtl/jk_excite_bit.sv
// rtl/jk_excite_bit.sv - per-bit JK excitation (set/reset form, or toggle form under JK_TOGGLE_EN)
module jk_excite_bit
    import jk_drv_pkg::*;
(
    input  logic tgt,
    input  logic q,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code = JK_HOLD;
`ifdef JK_TOGGLE_EN
        if (tgt != q) begin
            code = JK_TOGGLE;
        end
`else
        if (tgt != q) begin
            code = tgt ? JK_SET : JK_RESET;
        end
`endif
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives a JK flip-flop bank to a requested word with check and retry
// Optional macro JK_TOGGLE_EN selects toggle-form excitation with a single-cycle settle hold.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic             C,
    input  logic             RESETn,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef JK_TOGGLE_EN
    // A toggle code held across two edges would flip the bit back
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(1);
`else
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
`endif
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    drv_state_e          state_q, state_d;
    logic [WIDTH-1:0]    tgt_q, tgt_d;
    logic [WIDTH-1:0]    j_q, j_d;
    logic [WIDTH-1:0]    k_q, k_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_c, err_c;
    logic [WIDTH-1:0]    exc_j, exc_k;

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        jk_excite_bit u_bit (
            .tgt (tgt_q[i]),
            .q   (Q_fb[i]),
            .j   (exc_j[i]),
            .k   (exc_k[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        j_d      = j_q;
        k_d      = k_q;
        settle_d = settle_q;
        retry_d  = retry_q;
        done_c   = 1'b0;
        err_c    = 1'b0;

        case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    retry_d = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                j_d      = exc_j;
                k_d      = exc_k;
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q <= SETTLE_W'(1)) begin
                    settle_d = '0;
                    j_d      = '0;
                    k_d      = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            CHECK: begin
                j_d = '0;
                k_d = '0;
                if (Q_fb == tgt_q) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = DRIVE;
                end else begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge C or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            settle_q <= '0;
            retry_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            settle_q <= settle_d;
            retry_q  <= retry_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign tgt_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_c;
    assign err       = err_c;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - self-checking bench: JK bank model, transaction model and directed vectors
module tb_jk_excitation_driver;

    localparam int W     = 4;
    localparam int S_CYC = 1;
    localparam int MAXR  = 3;
`ifdef JK_TOGGLE_EN
    localparam int S_EFF = 1;
`else
    localparam int S_EFF = S_CYC;
`endif

    logic         C = 1'b0;
    logic         RESETn = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic         tgt_ready;
    logic [W-1:0] Q_fb, J, K;
    logic         busy, done, err;

    logic [W-1:0] bank = '0;
    logic         bank_load = 1'b0;
    logic [W-1:0] bank_val = '0;
    logic         tie_q = 1'b0;
    logic [W-1:0] tie_val = '0;
    logic         chk_on = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    assign Q_fb = tie_q ? tie_val : bank;

    always #5 C = ~C;

    jk_excitation_driver #(.WIDTH(W), .SETTLE_CYC(S_CYC), .MAX_RETRY(MAXR)) dut (
        .C         (C),
        .RESETn    (RESETn),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .Q_fb      (Q_fb),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // The driven bank: real master-slave JK flops, Q+ = J~Q | ~K Q
    always @(posedge C) begin
        if (bank_load) bank <= bank_val;
        else           bank <= (J & ~bank) | (~K & bank);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] excite(input logic [W-1:0] t, input logic [W-1:0] q);
`ifdef JK_TOGGLE_EN
        return {t ^ q, t ^ q};
`else
        return {t & ~q, ~t & q};
`endif
    endfunction

    // Transaction model: m_n is the cycle index within one attempt (0 = drive, 1..S_EFF = hold, S_EFF+1 = check)
    logic         m_active;
    int           m_n, m_att;
    logic [W-1:0] m_tgt, m_j, m_k;

    always @(posedge C or negedge RESETn) begin
        if (!RESETn) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_att    <= 0;
            m_tgt    <= '0;
            m_j      <= '0;
            m_k      <= '0;
        end else if (!m_active) begin
            if (tgt_valid) begin
                m_active <= 1'b1;
                m_tgt    <= tgt_data;
                m_n      <= 0;
                m_att    <= 0;
            end
        end else if (m_n == 0) begin
            {m_j, m_k} <= excite(m_tgt, Q_fb);
            m_n        <= 1;
        end else if (m_n <= S_EFF) begin
            m_n <= m_n + 1;
        end else if (Q_fb == m_tgt || m_att == MAXR) begin
            m_active <= 1'b0;
        end else begin
            m_att <= m_att + 1;
            m_n   <= 0;
        end
    end

    always @(negedge C) begin
        if (chk_on) begin
            logic         holding, checking;
            logic [W-1:0] ej, ek;
            holding  = m_active && m_n >= 1 && m_n <= S_EFF;
            checking = m_active && m_n == S_EFF + 1;
            ej = holding ? m_j : '0;
            ek = holding ? m_k : '0;
            check("cycle", 32'({J, K, tgt_ready, busy, done, err}),
                  32'({ej, ek, !m_active, m_active, checking && Q_fb == m_tgt,
                       checking && Q_fb != m_tgt && m_att == MAXR}));
        end
    end

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        bank_val  = v;
        bank_load = 1'b1;
        step();
        bank_load = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        tgt_data  = d;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
    endtask

    task automatic wait_end(output int cyc, output logic dn, output logic er,
                            output logic [W-1:0] jseen, output logic [W-1:0] kseen, output int drives);
        logic [W-1:0] prev;
        cyc = 0; dn = 1'b0; er = 1'b0; jseen = '0; kseen = '0; drives = 0; prev = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge C);
            cyc++;
            jseen |= J;
            kseen |= K;
            if ((J | K) != '0 && prev == '0) drives++;
            prev = J | K;
            if (done || err) begin
                dn = done;
                er = err;
                break;
            end
        end
        check("timeout", 32'(dn | er), 32'(1));
        step();
    endtask

    int           cyc, drv;
    logic         dn, er;
    logic [W-1:0] js, ks;

    initial begin
        #2 RESETn = 1'b0;
        #1 chk_on = 1'b1;
        @(posedge C); #1;
        load_bank(4'b0000);
        @(negedge C);
        check("rst_jk", 32'({J, K}), 32'(0));
        check("rst_hs", 32'({tgt_ready, busy, done, err}), 32'(4'b1000));
        #1 RESETn = 1'b1;
        step();
        @(negedge C);
        check("idle_hs", 32'({tgt_ready, busy, done, err}), 32'(4'b1000));
        step();

        // 0000 -> 1010
        send(4'b1010);
        wait_end(cyc, dn, er, js, ks, drv);
        check("t1_lat", 32'(cyc), 32'(3));
        check("t1_done", 32'({dn, er}), 32'(2'b10));
`ifdef JK_TOGGLE_EN
        check("t1_jk", 32'({js, ks}), 32'(8'b1010_1010));
`else
        check("t1_jk", 32'({js, ks}), 32'(8'b1010_0000));
`endif
        check("t1_bank", 32'(bank), 32'(4'b1010));

        // 1010 -> 0110
        send(4'b0110);
        wait_end(cyc, dn, er, js, ks, drv);
        check("t2_done", 32'({dn, er}), 32'(2'b10));
`ifdef JK_TOGGLE_EN
        check("t2_jk", 32'({js, ks}), 32'(8'b1100_1100));
`else
        check("t2_jk", 32'({js, ks}), 32'(8'b0100_1000));
`endif
        check("t2_bank", 32'(bank), 32'(4'b0110));

        // Target already present: full sequence, hold code only
        send(4'b0110);
        wait_end(cyc, dn, er, js, ks, drv);
        check("t3_lat", 32'(cyc), 32'(3));
        check("t3_jk", 32'({js, ks, dn}), 32'(9'b0000_0000_1));

        // Bank stuck at 0000: one drive plus MAXR retries, then err
        tie_val = 4'b0000;
        tie_q   = 1'b1;
        send(4'b1111);
        wait_end(cyc, dn, er, js, ks, drv);
        check("t4_drives", 32'(drv), 32'(4));
        check("t4_lat", 32'(cyc), 32'(12));
        check("t4_err", 32'({dn, er}), 32'(2'b01));
        tie_q = 1'b0;
        @(negedge C);
        check("t4_idle", 32'({tgt_ready, busy}), 32'(2'b10));
        step();

        // Valid held high with changing data while busy
        load_bank(4'b0110);
        tgt_data  = 4'b0011;
        tgt_valid = 1'b1;
        step();
        fork
            wait_end(cyc, dn, er, js, ks, drv);
            begin
                step(); tgt_data = 4'b1111;
                step(); tgt_data = 4'b1001;
            end
        join
        check("t5a_done", 32'({cyc, dn}), 32'({32'd3, 1'b1}));
`ifdef JK_TOGGLE_EN
        check("t5a_jk", 32'({js, ks}), 32'(8'b0101_0101));
`else
        check("t5a_jk", 32'({js, ks}), 32'(8'b0001_0100));
`endif
        @(negedge C);
        check("t5_gap", 32'({tgt_ready, busy}), 32'(2'b10));
        step();
        tgt_valid = 1'b0;
        wait_end(cyc, dn, er, js, ks, drv);
        check("t5b_lat", 32'(cyc), 32'(3));
`ifdef JK_TOGGLE_EN
        check("t5b_jk", 32'({js, ks}), 32'(8'b1010_1010));
`else
        check("t5b_jk", 32'({js, ks}), 32'(8'b1000_0010));
`endif
        check("t5b_bank", 32'(bank), 32'(4'b1001));

        // Reset during the hold phase
        send(4'b0110);
        @(negedge C);
        @(negedge C);
`ifdef JK_TOGGLE_EN
        check("t6_hold", 32'({J, K}), 32'(8'b1111_1111));
`else
        check("t6_hold", 32'({J, K}), 32'(8'b0110_1001));
`endif
        #2 RESETn = 1'b0;
        #1;
        check("t6_async", 32'({J, K, tgt_ready, busy}), 32'({8'h00, 2'b10}));
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            check("t6_nopulse", 32'({done, err}), 32'(0));
        end
        @(posedge C); #1;
        RESETn = 1'b1;
        @(negedge C);
        check("t6_idle", 32'({tgt_ready, busy}), 32'(2'b10));
        check("t6_bank", 32'(bank), 32'(4'b1001));
        step();

`ifdef JK_TOGGLE_EN
        load_bank(4'b0101);
        send(4'b0110);
        wait_end(cyc, dn, er, js, ks, drv);
        check("t7_jk", 32'({js, ks}), 32'(8'b0011_0011));
        check("t7_done", 32'({dn, er}), 32'(2'b10));
        check("t7_bank", 32'(bank), 32'(4'b0110));
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
